// File: rtl/muladd_sched_pkg.sv
// Shared definitions for the Muladd job scheduler: job descriptor layout,
// field widths and the scheduler FSM state encoding.
package muladd_sched_pkg;

    localparam int OPC_W   = 1;
    localparam int ITER_W  = 10;
    localparam int PER_W   = 10;
    localparam int SHIFT_W = 6;
    localparam int DELAY_W = 32;
    localparam int JOB_W   = OPC_W + ITER_W + PER_W + SHIFT_W + DELAY_W;

    // One queued job; field order is also the bit order of the packed word.
    typedef struct packed {
        logic               opcode;
        logic [ITER_W-1:0]  iterations;
        logic [PER_W-1:0]   period;
        logic [SHIFT_W-1:0] shift;
        logic [DELAY_W-1:0] delay0;
    } job_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_GUARD  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RETIRE = 3'd4
    } sched_state_e;

    // Assemble a descriptor from its individual fields.
    function automatic job_t make_job(
        input logic               opcode,
        input logic [ITER_W-1:0]  iterations,
        input logic [PER_W-1:0]   period,
        input logic [SHIFT_W-1:0] shift,
        input logic [DELAY_W-1:0] delay0
    );
        job_t j;
        j.opcode     = opcode;
        j.iterations = iterations;
        j.period     = period;
        j.shift      = shift;
        j.delay0     = delay0;
        return j;
    endfunction

endpackage

// File: rtl/muladd_job_fifo.sv
// Job queue: DEPTH-entry synchronous FIFO with push, pop, flush and
// full/empty flags. The head entry is read combinationally so the scheduler
// can latch it on the same edge that pops it. Flush empties the queue and
// overrides any push or pop on that edge.
module muladd_job_fifo
    import muladd_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = JOB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign do_push   = push & ~full & ~flush;
    assign do_pop    = pop & ~empty & ~flush;
    assign head_data = mem_q[rd_ptr_q];

    // Next pointer/occupancy: flush collapses the queue, otherwise track push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/muladd_job_sched.sv
// Muladd job scheduler: queues job descriptors and runs them one at a time
// on the Muladd unit (ISSUE -> GUARD -> WAIT -> RETIRE), counting completions.
// Optional build macro MULADD_JOB_SCHED_IRQ_EN adds a sticky completion
// interrupt (irq) with clear input (irq_clr).
module muladd_job_sched
    import muladd_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic               job_opcode,
    input  logic [ITER_W-1:0]  job_iterations,
    input  logic [PER_W-1:0]   job_period,
    input  logic [SHIFT_W-1:0] job_shift,
    input  logic [DELAY_W-1:0] job_delay,
    input  logic               flush,
    output logic               mul_opcode,
    output logic [ITER_W-1:0]  mul_iterations,
    output logic [PER_W-1:0]   mul_period,
    output logic [SHIFT_W-1:0] mul_shift,
    output logic [DELAY_W-1:0] mul_delay0,
    output logic               mul_run,
    input  logic               mul_done,
    output logic               busy,
    output logic [CNT_W-1:0]   jobs_done
`ifdef MULADD_JOB_SCHED_IRQ_EN
    ,
    output logic               irq,
    input  logic               irq_clr
`endif
);

    sched_state_e     state_q, state_d;
    job_t             cfg_q, cfg_d;
    logic [CNT_W-1:0] jobs_done_q, jobs_done_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [JOB_W-1:0] fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             can_issue;
    logic             retire;
    job_t             new_job;

    assign new_job   = make_job(job_opcode, job_iterations, job_period, job_shift, job_delay);
    // Ready is held low while reset is asserted, not just when the queue is full.
    assign job_ready = rst & ~fifo_full;
    assign fifo_push = job_valid & job_ready;
    // A flush on this edge empties the queue, so nothing may be issued from it.
    assign can_issue = ~fifo_empty & ~flush;

    muladd_job_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (JOB_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (new_job),
        .pop       (fifo_pop),
        .flush     (flush),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Scheduler next state, queue pop, start pulse and retire strobe.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        mul_run  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_issue) begin
                    state_d  = ST_ISSUE;
                    fifo_pop = 1'b1;
                end
            end
            ST_ISSUE: begin
                mul_run = 1'b1;
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                // The unit's done flag may still reflect the previous job here.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    state_d = ST_RETIRE;
                end
            end
            ST_RETIRE: begin
                retire = 1'b1;
                if (can_issue) begin
                    state_d  = ST_ISSUE;
                    fifo_pop = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Configuration latches the queue head on pop; the counter steps on retire.
    always_comb begin
        cfg_d       = cfg_q;
        jobs_done_d = jobs_done_q;
        if (fifo_pop) begin
            cfg_d = job_t'(fifo_head);
        end
        if (retire) begin
            jobs_done_d = jobs_done_q + 1'b1;
        end
    end

    // State, configuration and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign mul_opcode     = cfg_q.opcode;
    assign mul_iterations = cfg_q.iterations;
    assign mul_period     = cfg_q.period;
    assign mul_shift      = cfg_q.shift;
    assign mul_delay0     = cfg_q.delay0;
    assign jobs_done      = jobs_done_q;
    assign busy           = (state_q != ST_IDLE) | ~fifo_empty;

`ifdef MULADD_JOB_SCHED_IRQ_EN
    logic irq_q, irq_d;

    // Sticky interrupt: set when the last queued job retires; set beats clear.
    always_comb begin
        irq_d = irq_q;
        if (retire && fifo_empty) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // Interrupt register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_muladd_job_sched.sv
// Self-checking bench for muladd_job_sched: a job-level model (queue of
// descriptors, job in flight with its age since start) predicts every output
// each cycle; directed scenarios pin the model with literal values, then a
// randomized phase exercises pushes, flushes and unit stalls.
`timescale 1ns/1ps
module tb_muladd_job_sched;
    import muladd_sched_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               job_valid;
    logic               job_ready;
    logic               job_opcode;
    logic [9:0]         job_iterations;
    logic [9:0]         job_period;
    logic [5:0]         job_shift;
    logic [31:0]        job_delay;
    logic               flush;
    logic               mul_opcode;
    logic [9:0]         mul_iterations;
    logic [9:0]         mul_period;
    logic [5:0]         mul_shift;
    logic [31:0]        mul_delay0;
    logic               mul_run;
    logic               mul_done;
    logic               busy;
    logic [CNT_W-1:0]   jobs_done;
`ifdef MULADD_JOB_SCHED_IRQ_EN
    logic               irq;
    logic               irq_clr;
`endif

    always #5 clk = ~clk;

    muladd_job_sched #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_opcode     (job_opcode),
        .job_iterations (job_iterations),
        .job_period     (job_period),
        .job_shift      (job_shift),
        .job_delay      (job_delay),
        .flush          (flush),
        .mul_opcode     (mul_opcode),
        .mul_iterations (mul_iterations),
        .mul_period     (mul_period),
        .mul_shift      (mul_shift),
        .mul_delay0     (mul_delay0),
        .mul_run        (mul_run),
        .mul_done       (mul_done),
        .busy           (busy),
        .jobs_done      (jobs_done)
`ifdef MULADD_JOB_SCHED_IRQ_EN
        ,
        .irq            (irq),
        .irq_clr        (irq_clr)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Job-level model
    job_t m_q[$];
    job_t m_cur;
    bit   m_inflight;
    int   m_age;
    bit   m_retiring;
    int   m_done_cnt;
    bit   m_irq;

    int   cyc;
    int   run_cnt;
    int   run_cyc[$];
    int   acc_cnt;
    int   irq_hi;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur      = '0;
        m_inflight = 1'b0;
        m_age      = 0;
        m_retiring = 1'b0;
        m_done_cnt = 0;
        m_irq      = 1'b0;
    endtask

    // Compare every DUT output against the model (called between edges).
    task automatic check_outputs();
        bit   e_run;
        job_t act_cfg;
        e_run   = m_inflight && !m_retiring && (m_age == 0);
        act_cfg = make_job(mul_opcode, mul_iterations, mul_period, mul_shift, mul_delay0);
        chk("mul_run", 64'(mul_run), 64'(e_run));
        chk("busy", 64'(busy), 64'(m_inflight || (m_q.size() > 0)));
        chk("job_ready", 64'(job_ready), 64'(m_q.size() < DEPTH));
        chk("jobs_done", 64'(jobs_done), 64'(m_done_cnt));
        chk("mul_cfg", 64'(act_cfg), 64'(m_cur));
`ifdef MULADD_JOB_SCHED_IRQ_EN
        chk("irq", 64'(irq), 64'(m_irq));
        if (irq) irq_hi++;
`endif
        if (mul_run) begin
            run_cnt++;
            run_cyc.push_back(cyc);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic cycle(input bit v, input job_t j, input bit fl, input bit dn, input bit clr);
        bit ready;
        bit push;
        job_valid      = v;
        job_opcode     = j.opcode;
        job_iterations = j.iterations;
        job_period     = j.period;
        job_shift      = j.shift;
        job_delay      = j.delay0;
        flush          = fl;
        mul_done       = dn;
`ifdef MULADD_JOB_SCHED_IRQ_EN
        irq_clr        = clr;
`endif
        if (v && job_ready) acc_cnt++;

        ready = (m_q.size() < DEPTH);
        push  = v && ready && !fl;
        if (m_retiring && (m_q.size() == 0)) m_irq = 1'b1;
        else if (clr) m_irq = 1'b0;

        if (!m_inflight) begin
            if ((m_q.size() > 0) && !fl) begin
                m_cur      = m_q.pop_front();
                m_inflight = 1'b1;
                m_age      = 0;
            end
        end else if (m_retiring) begin
            m_done_cnt = (m_done_cnt + 1) % (1 << CNT_W);
            m_retiring = 1'b0;
            if ((m_q.size() > 0) && !fl) begin
                m_cur = m_q.pop_front();
                m_age = 0;
            end else begin
                m_inflight = 1'b0;
            end
        end else if (m_age >= 2) begin
            if (dn) m_retiring = 1'b1;
        end else begin
            m_age++;
        end
        if (fl) m_q.delete();
        if (push) m_q.push_back(j);

        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    function automatic job_t rand_job();
        job_t j;
        j.opcode     = 1'($urandom);
        j.iterations = 10'($urandom);
        j.period     = 10'($urandom);
        j.shift      = 6'($urandom);
        j.delay0     = $urandom;
        return j;
    endfunction

    function automatic job_t tag_job(input int tag);
        job_t j;
        j            = rand_job();
        j.iterations = 10'(tag);
        return j;
    endfunction

    initial begin
        job_t j0;
        job_t j1;
        j0 = '0;
        rst            = 1'b0;
        job_valid      = 1'b0;
        job_opcode     = 1'b0;
        job_iterations = '0;
        job_period     = '0;
        job_shift      = '0;
        job_delay      = '0;
        flush          = 1'b0;
        mul_done       = 1'b1;
`ifdef MULADD_JOB_SCHED_IRQ_EN
        irq_clr        = 1'b0;
`endif
        cyc = 0; run_cnt = 0; acc_cnt = 0; irq_hi = 0;
        model_reset();

        // Reset state
        #1;
        chk("rst_run", 64'(mul_run), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(job_ready), 64'd0);
        chk("rst_jobs_done", 64'(jobs_done), 64'd0);
        chk("rst_delay0", 64'(mul_delay0), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs();

        // Single job, unit stalled 12 cycles
        j1 = make_job(1'b1, 10'd8, 10'd8, 6'd0, 32'd2);
        run_cnt = 0;
        cycle(1'b1, j1, 1'b0, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, j0, 1'b0, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, j0, 1'b0, 1'b1, 1'b0);
        chk("t1_runs", 64'(run_cnt), 64'd1);
        chk("t1_jobs_done", 64'(jobs_done), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_iter", 64'(mul_iterations), 64'd8);
        chk("t1_delay0", 64'(mul_delay0), 64'd2);
        chk("t1_opcode", 64'(mul_opcode), 64'd1);

        // Back-to-back jobs with done held high
        run_cyc.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, tag_job(100 + i), 1'b0, 1'b1, 1'b0);
        repeat (16) cycle(1'b0, j0, 1'b0, 1'b1, 1'b0);
        chk("t2_nruns", 64'(run_cyc.size()), 64'd3);
        if (run_cyc.size() == 3) begin
            chk("t2_gap0", 64'(run_cyc[1] - run_cyc[0]), 64'd4);
            chk("t2_gap1", 64'(run_cyc[2] - run_cyc[1]), 64'd4);
        end
        chk("t2_jobs_done", 64'(jobs_done), 64'd4);
        chk("t2_last_iter", 64'(mul_iterations), 64'd102);

        // Fill the queue while the unit is stalled
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, tag_job(200 + i), 1'b0, 1'b0, 1'b0);
        chk("t3_accepted", 64'(acc_cnt), 64'd5);
        chk("t3_ready_low", 64'(job_ready), 64'd0);
        repeat (30) cycle(1'b0, j0, 1'b0, 1'b1, 1'b0);
        chk("t3_jobs_done", 64'(jobs_done), 64'd9);
        chk("t3_last_iter", 64'(mul_iterations), 64'd204);

        // Flush with one job in WAIT and three queued
        for (int i = 0; i < 4; i++) cycle(1'b1, tag_job(300 + i), 1'b0, 1'b0, 1'b0);
        run_cnt = 0;
        cycle(1'b0, j0, 1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, j0, 1'b0, 1'b1, 1'b0);
        chk("t4_runs", 64'(run_cnt), 64'd0);
        chk("t4_jobs_done", 64'(jobs_done), 64'd10);
        chk("t4_iter", 64'(mul_iterations), 64'd300);
        chk("t4_busy", 64'(busy), 64'd0);

        // Reset in the middle of WAIT
        cycle(1'b1, tag_job(400), 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, j0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("t5_run", 64'(mul_run), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_ready", 64'(job_ready), 64'd0);
        chk("t5_jobs_done", 64'(jobs_done), 64'd0);
        chk("t5_iter", 64'(mul_iterations), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs();
        cycle(1'b1, tag_job(500), 1'b0, 1'b1, 1'b0);
        repeat (8) cycle(1'b0, j0, 1'b0, 1'b1, 1'b0);
        chk("t5_after_jobs_done", 64'(jobs_done), 64'd1);
        chk("t5_after_iter", 64'(mul_iterations), 64'd500);

`ifdef MULADD_JOB_SCHED_IRQ_EN
        chk("t6_irq_set", 64'(irq), 64'd1);
        cycle(1'b0, j0, 1'b0, 1'b1, 1'b1);
        chk("t6_irq_clr", 64'(irq), 64'd0);
        irq_hi = 0;
        cycle(1'b1, tag_job(600), 1'b0, 1'b1, 1'b1);
        repeat (8) cycle(1'b0, j0, 1'b0, 1'b1, 1'b1);
        chk("t6_irq_pulse", 64'(irq_hi), 64'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 1)), rand_job(), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end
        repeat (40) cycle(1'b0, j0, 1'b0, 1'b1, 1'b0);
        chk("drain_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
